// File: rtl/bp_piton_pkg.sv
// Shared types and constants for the BlackParrot -> L1.5 request arbiter slice.
package bp_piton_pkg;

    typedef enum logic {
        e_empty,
        e_full
    } bp_piton_arb_state_e;

    localparam int unsigned bp_piton_req_icache_gp = 0;
    localparam int unsigned bp_piton_req_dcache_gp = 1;

endpackage

// File: rtl/bp_piton_rr_arb.sv
// Round-robin arbiter: first asserted request at or after ptr (wrapping) wins.
module bp_piton_rr_arb
#(
    parameter  int unsigned NUM_REQ    = 2,
    localparam int unsigned LG_NUM_REQ = $clog2(NUM_REQ)
)
(
    input  logic [NUM_REQ-1:0]    req,
    input  logic [LG_NUM_REQ-1:0] ptr,
    output logic [NUM_REQ-1:0]    grant,
    output logic [LG_NUM_REQ-1:0] idx,
    output logic                  v
);

    logic [NUM_REQ-1:0]  rot;
    logic [LG_NUM_REQ:0] pos;

    // Rotate so that bit 0 is the pointer position, then pick the lowest set bit.
    always_comb begin
        rot = NUM_REQ'({req, req} >> ptr);
        v   = 1'b0;
        idx = '0;
        pos = '0;
        for (int unsigned j = 0; j < NUM_REQ; j++) begin
            if (!v && rot[j]) begin
                v   = 1'b1;
                pos = {1'b0, ptr} + (LG_NUM_REQ+1)'(j);
                if (pos >= (LG_NUM_REQ+1)'(NUM_REQ)) begin
                    pos = pos - (LG_NUM_REQ+1)'(NUM_REQ);
                end
                idx = LG_NUM_REQ'(pos);
            end
        end
    end

    always_comb begin
        grant = '0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            grant[k] = v && (idx == LG_NUM_REQ'(k));
        end
    end

endmodule

// File: rtl/bp_piton_l15_req_arbiter.sv
// Arbitrates the cache engines onto the single L1.5 request channel with per-requester credits.
// Define BP_PITON_ARB_FIXED_PRIO_EN for fixed priority (highest index wins) instead of round-robin.
module bp_piton_l15_req_arbiter
    import bp_piton_pkg::*;
#(
    parameter  int unsigned NUM_REQ         = bp_piton_req_dcache_gp + 1,
    parameter  int unsigned REQ_W           = 128,
    parameter  int unsigned MAX_OUTSTANDING = 2,
    localparam int unsigned LG_NUM_REQ      = $clog2(NUM_REQ)
)
(
    input  logic                       clk_i,
    input  logic                       rst_n_i,
    input  logic [NUM_REQ-1:0]         req_v_i,
    input  logic [NUM_REQ*REQ_W-1:0]   req_data_i,
    output logic [NUM_REQ-1:0]         req_ready_o,
    output logic                       l15_v_o,
    output logic [REQ_W-1:0]           l15_data_o,
    output logic [LG_NUM_REQ-1:0]      l15_src_o,
    input  logic                       l15_yumi_i,
    input  logic                       resp_v_i,
    input  logic [LG_NUM_REQ-1:0]      resp_src_i,
    output logic                       busy_o,
    output logic                       err_o
);

    localparam int unsigned CNT_W = $clog2(MAX_OUTSTANDING + 1);

    bp_piton_arb_state_e state_r, state_n;

    logic [REQ_W-1:0]      data_r;
    logic [LG_NUM_REQ-1:0] src_r;
    logic [CNT_W-1:0]      cnt_r [NUM_REQ];
    logic [CNT_W-1:0]      cnt_n [NUM_REQ];
    logic                  err_r;

    logic [NUM_REQ-1:0]    eligible;
    logic [NUM_REQ-1:0]    win_oh;
    logic [LG_NUM_REQ-1:0] win_idx;
    logic                  win_v;
    logic                  grant_en;
    logic                  grant;
    logic [REQ_W-1:0]      sel_data;
    logic [NUM_REQ-1:0]    resp_hit;
    logic                  resp_bad_src;
    logic                  resp_no_credit;
    logic                  any_cnt;
    logic                  err_set;

    always_comb begin
        eligible = '0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            eligible[k] = req_v_i[k] && (cnt_r[k] < CNT_W'(MAX_OUTSTANDING));
        end
    end

`ifdef BP_PITON_ARB_FIXED_PRIO_EN
    always_comb begin
        win_v   = 1'b0;
        win_idx = '0;
        win_oh  = '0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            if (eligible[k]) begin
                win_v   = 1'b1;
                win_idx = LG_NUM_REQ'(k);
            end
        end
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            win_oh[k] = win_v && (win_idx == LG_NUM_REQ'(k));
        end
    end
`else
    logic [LG_NUM_REQ-1:0] ptr_r;

    bp_piton_rr_arb #(
        .NUM_REQ (NUM_REQ)
    ) rr_arb (
        .req   (eligible),
        .ptr   (ptr_r),
        .grant (win_oh),
        .idx   (win_idx),
        .v     (win_v)
    );

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            ptr_r <= LG_NUM_REQ'(bp_piton_req_icache_gp);
        end else if (grant) begin
            ptr_r <= (win_idx == LG_NUM_REQ'(NUM_REQ - 1)) ? '0 : win_idx + 1'b1;
        end
    end
`endif

    // Gating with reset keeps req_ready_o low while the block is held in reset.
    assign grant_en    = rst_n_i && ((state_r == e_empty) || l15_yumi_i);
    assign grant       = grant_en && win_v;
    assign req_ready_o = grant ? win_oh : '0;

    always_comb begin
        sel_data = '0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            if (win_idx == LG_NUM_REQ'(k)) begin
                sel_data = req_data_i[k*REQ_W +: REQ_W];
            end
        end
    end

    always_comb begin
        state_n = state_r;
        if (grant_en) begin
            state_n = win_v ? e_full : e_empty;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_r <= e_empty;
            data_r  <= '0;
            src_r   <= '0;
        end else begin
            state_r <= state_n;
            if (grant) begin
                data_r <= sel_data;
                src_r  <= win_idx;
            end
        end
    end

    // Credit is taken at grant, so the held slot already counts as in flight.
    always_comb begin
        resp_hit       = '0;
        resp_no_credit = 1'b0;
        any_cnt        = 1'b0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            cnt_n[k]    = cnt_r[k];
            resp_hit[k] = resp_v_i && (resp_src_i == LG_NUM_REQ'(k));
            if (resp_hit[k] && (cnt_r[k] == '0)) begin
                resp_no_credit = 1'b1;
            end
            if ((grant && win_oh[k]) && !(resp_hit[k] && (cnt_r[k] != '0))) begin
                cnt_n[k] = cnt_r[k] + 1'b1;
            end else if (!(grant && win_oh[k]) && resp_hit[k] && (cnt_r[k] != '0)) begin
                cnt_n[k] = cnt_r[k] - 1'b1;
            end
            if (cnt_r[k] != '0) begin
                any_cnt = 1'b1;
            end
        end
    end

    assign resp_bad_src = resp_v_i && ({1'b0, resp_src_i} >= (LG_NUM_REQ+1)'(NUM_REQ));
    assign err_set      = resp_bad_src || resp_no_credit || (l15_yumi_i && (state_r == e_empty));

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            for (int unsigned k = 0; k < NUM_REQ; k++) begin
                cnt_r[k] <= '0;
            end
            err_r <= 1'b0;
        end else begin
            for (int unsigned k = 0; k < NUM_REQ; k++) begin
                cnt_r[k] <= cnt_n[k];
            end
            if (err_set) begin
                err_r <= 1'b1;
            end
        end
    end

    assign l15_v_o    = (state_r == e_full);
    assign l15_data_o = data_r;
    assign l15_src_o  = src_r;
    assign busy_o     = any_cnt || (state_r == e_full);
    assign err_o      = err_r;

endmodule
